reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file with ROB-tag renaming, downstream of the reorder buffer's commit port.
//  Sits between the decoder and the reorder buffer.
//  Holds 32x32-bit committed values plus a per-register busy bit and producing ROB id.
//  Decoder reads operands combinationally; ROB drives issue-time rename and commit-time writeback.
// PARAMETERS
//  ROB_SIZE_WIDTH  4  width of a ROB entry id (ROB depth = 2**ROB_SIZE_WIDTH)
// PORTS
//  clk            in   1               system clock, all state updates on posedge
//  rst            in   1               synchronous, active-high reset
//  rdy            in   1               global enable; low = freeze all state
//  clear          in   1               mispredict flush from ROB
//  issue_rd       in   5               rd being renamed this cycle (0 = no rename)
//  issue_rob_id   in   ROB_SIZE_WIDTH  ROB entry that will produce issue_rd
//  commit_rd      in   5               rd retiring this cycle (0 = no write)
//  commit_rob_id  in   ROB_SIZE_WIDTH  ROB entry retiring
//  commit_value   in   32              value retiring
//  rs1            in   5               decoder source register 1
//  rs2            in   5               decoder source register 2
//  rs1_value      out  32              operand value for rs1 when rs1_busy=0
//  rs1_busy       out  1               1 = rs1 awaits ROB entry rs1_rob_id
//  rs1_rob_id     out  ROB_SIZE_WIDTH  producing ROB entry for rs1 (0 when not busy)
//  rs2_value, rs2_busy, rs2_rob_id     same as rs1_* for rs2
// BEHAVIOUR
//  Clock/reset
//  - Single clock clk.
//  - Reset rst is synchronous and active-high.
//  - On rst: all values[i]=0, busy[i]=0, tag[i]=0. rst takes priority over rdy and clear.
//  - rdy=0: no state change. Read outputs remain combinational.
//  Commit (posedge, rdy=1, commit_rd!=0)
//  - values[commit_rd] <= commit_value.
//  - busy[commit_rd] <= 0 only if busy[commit_rd] && tag[commit_rd]==commit_rob_id.
//  - Otherwise the busy bit and tag are kept, because a younger writer is pending.
//  Issue (posedge, rdy=1, clear=0, issue_rd!=0)
//  - busy[issue_rd] <= 1; tag[issue_rd] <= issue_rob_id.
//  - Same-cycle issue and commit to the same rd: the commit value is written, and the issue tag/busy wins.
//  Clear (posedge, rdy=1, clear=1)
//  - Commit writeback of the same cycle is still applied.
//  - Then all busy=0 and tag=0.
//  - Issue is ignored in that cycle.
//  x0
//  - Never written, never busy; reads of x0 return value 0, busy 0, rob_id 0.
//  Read (combinational, pre-issue state; per source s)
//  - If !busy[s]: value=values[s], busy=0.
//  - Else if rdy && commit_rd==s && commit_rob_id==tag[s]: value=commit_value, busy=0 (commit bypass).
//  - Else: busy=1, rob_id=tag[s], value=0.
//  - The decoder's own issue in the same cycle never affects its operand reads.
//  - When busy=0, rob_id=0.
//  - Zero latency from input change to read outputs.
//  Notes
//  - Out-of-range conditions do not exist: all 5-bit indices are valid.
//  - ROB-id width is the only parameterised width.
// TESTING
//  1 Reset, then read rs1=5, rs2=31 -> value 0, busy 0, rob_id 0 for both.
//  2 Issue rd=3 id=2; next cycle read rs1=3 -> busy 1, rob_id 2.
//    Then commit rd=3 id=2 val=0xDEADBEEF -> bypass value 0xDEADBEEF, busy 0 same cycle.
//    Next cycle: stored, not busy.
//  3 Issue rd=7 id=1, then issue rd=7 id=4; commit rd=7 id=1 val=0x11 -> values[7]=0x11, still busy, tag 4.
//    Commit id=4 val=0x22 -> not busy, value 0x22.
//  4 Same cycle: commit rd=9 id=5 val=0xAA and issue rd=9 id=6 -> values[9]=0xAA, busy 1, tag 6.
//  5 Rename x1,x2,x3 (ids 1..3); clear with commit rd=1 id=1 val=0x55 -> all not busy, x1=0x55.
//    An issue in the clear cycle has no effect.
//  6 Hold rdy=0, then issue rd=4 and commit rd=4 val=0x99 -> no change.
//    Issue rd=0 or commit rd=0 -> x0 stays 0, not busy.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with ROB-tag renaming: 32x32 committed values,
// per-register busy bit and producing ROB id, combinational operand reads with commit bypass.
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               rs1_value,
  output logic                      rs1_busy,
  output logic [ROB_SIZE_WIDTH-1:0] rs1_rob_id,
  output logic [31:0]               rs2_value,
  output logic                      rs2_busy,
  output logic [ROB_SIZE_WIDTH-1:0] rs2_rob_id
);

  logic [31:0]               values [32];
  logic [31:0]               busy;
  logic [ROB_SIZE_WIDTH-1:0] tag    [32];

  // Later non-blocking writes override earlier ones: issue beats commit, clear beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < 32; i++) begin
        values[i] <= '0;
        tag[i]    <= '0;
      end
    end else if (rdy) begin
      if (commit_rd != 5'd0) begin
        values[commit_rd] <= commit_value;
        if (busy[commit_rd] && (tag[commit_rd] == commit_rob_id))
          busy[commit_rd] <= 1'b0;
      end
      if (clear) begin
        busy <= '0;
        for (int i = 0; i < 32; i++)
          tag[i] <= '0;
      end else if (issue_rd != 5'd0) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd]  <= issue_rob_id;
      end
    end
  end

  // Reads see pre-issue state; a retiring producer is forwarded in the same cycle.
  always_comb begin
    rs1_value  = '0;
    rs1_busy   = 1'b0;
    rs1_rob_id = '0;
    if (rs1 == 5'd0) begin
      rs1_value = '0;
    end else if (!busy[rs1]) begin
      rs1_value = values[rs1];
    end else if (rdy && (commit_rd == rs1) && (commit_rob_id == tag[rs1])) begin
      rs1_value = commit_value;
    end else begin
      rs1_busy   = 1'b1;
      rs1_rob_id = tag[rs1];
    end
  end

  always_comb begin
    rs2_value  = '0;
    rs2_busy   = 1'b0;
    rs2_rob_id = '0;
    if (rs2 == 5'd0) begin
      rs2_value = '0;
    end else if (!busy[rs2]) begin
      rs2_value = values[rs2];
    end else if (rdy && (commit_rd == rs2) && (commit_rob_id == tag[rs2])) begin
      rs2_value = commit_value;
    end else begin
      rs2_busy   = 1'b1;
      rs2_rob_id = tag[rs2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, bypass, clear, freeze and x0 handling.
module tb_reg_file;
  localparam int RW = 4;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          clear;
  logic [4:0]    issue_rd;
  logic [RW-1:0] issue_rob_id;
  logic [4:0]    commit_rd;
  logic [RW-1:0] commit_rob_id;
  logic [31:0]   commit_value;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   rs1_value;
  logic          rs1_busy;
  logic [RW-1:0] rs1_rob_id;
  logic [31:0]   rs2_value;
  logic          rs2_busy;
  logic [RW-1:0] rs2_rob_id;

  int checks = 0;
  int errors = 0;

  reg_file #(.ROB_SIZE_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
    .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] v, input logic b, input logic [RW-1:0] id);
    chk({name, ".rs1_value"},  rs1_value,        v);
    chk({name, ".rs1_busy"},   32'(rs1_busy),    32'(b));
    chk({name, ".rs1_rob_id"}, 32'(rs1_rob_id),  32'(id));
  endtask

  task automatic chk2(input string name, input logic [31:0] v, input logic b, input logic [RW-1:0] id);
    chk({name, ".rs2_value"},  rs2_value,        v);
    chk({name, ".rs2_busy"},   32'(rs2_busy),    32'(b));
    chk({name, ".rs2_rob_id"}, 32'(rs2_rob_id),  32'(id));
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0;
    issue_rd = 5'd0; issue_rob_id = '0;
    commit_rd = 5'd0; commit_rob_id = '0; commit_value = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // 1: reset state
    rs1 = 5'd5; rs2 = 5'd31; #1;
    chk1("reset_x5", 32'h0, 1'b0, 4'd0);
    chk2("reset_x31", 32'h0, 1'b0, 4'd0);

    // 2: issue, busy read, commit bypass, stored
    issue_rd = 5'd3; issue_rob_id = 4'd2;
    tick(); idle();
    rs1 = 5'd3; #1;
    chk1("x3_busy", 32'h0, 1'b1, 4'd2);
    commit_rd = 5'd3; commit_rob_id = 4'd2; commit_value = 32'hDEADBEEF; #1;
    chk1("x3_bypass", 32'hDEADBEEF, 1'b0, 4'd0);
    tick(); idle(); #1;
    chk1("x3_stored", 32'hDEADBEEF, 1'b0, 4'd0);

    // 3: stale commit keeps the younger tag
    issue_rd = 5'd7; issue_rob_id = 4'd1;
    tick();
    issue_rd = 5'd7; issue_rob_id = 4'd4;
    tick(); idle();
    commit_rd = 5'd7; commit_rob_id = 4'd1; commit_value = 32'h11;
    rs1 = 5'd7; #1;
    chk1("x7_stale_commit_nobypass", 32'h0, 1'b1, 4'd4);
    tick(); idle(); #1;
    chk1("x7_still_busy", 32'h0, 1'b1, 4'd4);
    commit_rd = 5'd7; commit_rob_id = 4'd4; commit_value = 32'h22; #1;
    chk1("x7_bypass", 32'h22, 1'b0, 4'd0);
    tick(); idle(); #1;
    chk1("x7_stored", 32'h22, 1'b0, 4'd0);

    // 4: same-cycle commit and issue to one register
    commit_rd = 5'd9; commit_rob_id = 4'd5; commit_value = 32'hAA;
    issue_rd = 5'd9; issue_rob_id = 4'd6;
    rs2 = 5'd9; #1;
    chk2("x9_pre_issue_read", 32'h0, 1'b0, 4'd0);
    tick(); idle(); #1;
    chk2("x9_issue_wins", 32'h0, 1'b1, 4'd6);

    // 5: clear with a commit and an ignored issue
    issue_rd = 5'd1; issue_rob_id = 4'd1; tick();
    issue_rd = 5'd2; issue_rob_id = 4'd2; tick();
    issue_rd = 5'd3; issue_rob_id = 4'd3; tick();
    idle();
    rs1 = 5'd2; #1;
    chk1("x2_busy_before_clear", 32'h0, 1'b1, 4'd2);
    clear = 1'b1;
    commit_rd = 5'd1; commit_rob_id = 4'd1; commit_value = 32'h55;
    issue_rd = 5'd5; issue_rob_id = 4'd7;
    tick(); idle();
    rs1 = 5'd1; rs2 = 5'd2; #1;
    chk1("clear_x1", 32'h55, 1'b0, 4'd0);
    chk2("clear_x2", 32'h0, 1'b0, 4'd0);
    rs1 = 5'd3; rs2 = 5'd9; #1;
    chk1("clear_x3", 32'hDEADBEEF, 1'b0, 4'd0);
    chk2("clear_x9", 32'hAA, 1'b0, 4'd0);
    rs1 = 5'd5; rs2 = 5'd7; #1;
    chk1("clear_x5_issue_ignored", 32'h0, 1'b0, 4'd0);
    chk2("clear_x7", 32'h22, 1'b0, 4'd0);

    // 6: rdy=0 freezes state and suppresses bypass
    rdy = 1'b0;
    issue_rd = 5'd4; issue_rob_id = 4'd3;
    commit_rd = 5'd4; commit_rob_id = 4'd0; commit_value = 32'h99;
    tick(); tick(); idle();
    rs1 = 5'd4; #1;
    chk1("frozen_x4", 32'h0, 1'b0, 4'd0);
    issue_rd = 5'd4; issue_rob_id = 4'd3;
    tick(); idle();
    rdy = 1'b0;
    commit_rd = 5'd4; commit_rob_id = 4'd3; commit_value = 32'h99; #1;
    chk1("x4_no_bypass_when_frozen", 32'h0, 1'b1, 4'd3);
    tick(); idle(); #1;
    chk1("x4_still_busy", 32'h0, 1'b1, 4'd3);
    commit_rd = 5'd4; commit_rob_id = 4'd3; commit_value = 32'h99;
    tick(); idle(); #1;
    chk1("x4_committed", 32'h99, 1'b0, 4'd0);

    // x0 never written, never busy
    issue_rd = 5'd0; issue_rob_id = 4'd5;
    commit_rd = 5'd0; commit_rob_id = 4'd5; commit_value = 32'hFFFF_FFFF;
    rs1 = 5'd0; rs2 = 5'd0; #1;
    chk1("x0_same_cycle", 32'h0, 1'b0, 4'd0);
    tick(); idle(); #1;
    chk2("x0_after", 32'h0, 1'b0, 4'd0);

    // reset takes priority over a concurrent issue/commit
    rst = 1'b1;
    issue_rd = 5'd10; issue_rob_id = 4'd9;
    commit_rd = 5'd9; commit_rob_id = 4'd0; commit_value = 32'h1234;
    tick(); rst = 1'b0; idle();
    rs1 = 5'd9; rs2 = 5'd10; #1;
    chk1("rst_x9", 32'h0, 1'b0, 4'd0);
    chk2("rst_x10", 32'h0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
